// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch address sequencer.
//
// Drives the fetch address into a one-cycle-latency instruction memory and
// tracks which address is currently on the memory's inst output. After reset
// it spends BOOT_CYCLES cycles in BOOT, then fetches sequentially from
// RESET_PC. Taken jumps from execute redirect the stream and stalls from the
// hazard logic freeze it.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   stall_in     in   hazard stall request
//   jump_in      in   taken branch/jump request
//   jump_target  in   [31:0] byte address of the redirect
//   pc           out  [31:0] fetch address (memory indexes pc[31:2])
//   is_jump      out  memory loads a bubble into inst
//   is_stoll     out  memory holds inst
//   id_pc        out  [31:0] address of the instruction on inst
//   id_valid     out  inst/id_pc hold a real instruction
//   misalign_err out  one-cycle pulse after a jump to a non-word-aligned target
//   fetch_count  out  [31:0] instructions handed to decode
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | post-reset wait, memory fed bubbles, inputs ignored
// REDIRECT | pc holds a fresh target, inst is a bubble (id_valid=0)
// RUN      | sequential fetch, inst holds a real instruction

module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        jump_in,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic        is_jump,
    output logic        is_stoll,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        REDIRECT = 2'd1,
        RUN      = 2'd2
    } state_t;

    // Count value on which the BOOT_CYCLES-th edge leaves BOOT.
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  boot_cnt_q;
    logic [31:0] pc_q;
    logic [31:0] id_pc_q;
    logic [31:0] fetch_count_q;
    logic        misalign_q;
    logic        in_boot;

    assign in_boot = (state_q == BOOT);

    // BOOT always feeds bubbles; afterwards a jump wins over a stall.
    assign is_jump  = in_boot | jump_in;
    assign is_stoll = stall_in & ~is_jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            boot_cnt_q    <= 4'd0;
            pc_q          <= RESET_PC;
            id_pc_q       <= 32'h0000_0000;
            fetch_count_q <= 32'h0000_0000;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_q    <= REDIRECT;
                        boot_cnt_q <= 4'd0;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + 4'd1;
                    end
                end
                default: begin
                    if (jump_in) begin
                        // id_pc is left alone: inst becomes a bubble anyway.
                        pc_q       <= {jump_target[31:2], 2'b00};
                        state_q    <= REDIRECT;
                        misalign_q <= |jump_target[1:0];
                    end else if (!stall_in) begin
                        pc_q    <= pc_q + 32'd4;
                        id_pc_q <= pc_q;
                        state_q <= RUN;
                        if (state_q == RUN) begin
                            fetch_count_q <= fetch_count_q + 32'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign id_pc        = id_pc_q;
    assign id_valid     = (state_q == RUN);
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-003 Parameter: BOOT_CYCLES, 2, number of post-reset cycles spent in BOOT; legal range 1..15.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: stall_in  input  1  hazard stall request from the decode/hazard logic.
REQ-007 Port: jump_in  input  1  taken branch/jump request from execute.
REQ-008 Port: jump_target  input  32  byte address of the redirect.
REQ-009 Port: pc  output  32  fetch address to the instruction/data memory; memory indexes pc[31:2].
REQ-010 Port: is_jump  output  1  to memory; memory loads 0 (bubble) into inst.
REQ-011 Port: is_stoll  output  1  to memory; memory holds inst.
REQ-012 Port: id_pc  output  32  address of the instruction currently on the memory inst output.
REQ-013 Port: id_valid  output  1  inst/id_pc hold a real instruction.
REQ-014 Port: misalign_err  output  1  one-cycle pulse: last accepted jump_target had nonzero bits [1:0].
REQ-015 Port: fetch_count  output  32  number of instructions handed to decode.

Function
REQ-016 The block SHALL implement states BOOT, REDIRECT, RUN; id_valid SHALL equal (state==RUN).
REQ-017 Memory inst latency is one cycle; pc presented in cycle n SHALL appear as id_pc in cycle n+1 whenever that edge is not a stall or jump.
REQ-018 BOOT: is_jump=1, is_stoll=0, pc held at RESET_PC, jump_in and stall_in ignored; a 4-bit counter SHALL leave BOOT for REDIRECT on the BOOT_CYCLES-th edge after reset release.
REQ-019 A jump is accepted when jump_in=1 and state is REDIRECT or RUN; accepted jump: is_jump=1, pc <= {jump_target[31:2],2'b00}, state -> REDIRECT, id_pc held.
REQ-020 Jump priority: jump_in=1 with stall_in=1 SHALL be treated as a jump; is_stoll = stall_in & ~is_jump at all times.
REQ-021 Stall (stall_in=1, no accepted jump): pc, id_pc, state, fetch_count held; id_valid unchanged.
REQ-022 Neither stall nor jump, state REDIRECT or RUN: pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), id_pc <= pc, state -> RUN.
REQ-023 Jump while in REDIRECT SHALL restart REDIRECT with the new target (back-to-back redirects legal).
REQ-024 fetch_count SHALL increment by 1 on each edge with id_valid=1, stall_in=0, jump_in=0; wraps to 0 after 32'hFFFF_FFFF.
REQ-025 misalign_err SHALL be registered: 1 for exactly the cycle after an accepted jump whose jump_target[1:0]!=0, else 0.
REQ-026 is_jump and is_stoll SHALL be combinational from state and inputs; all other outputs SHALL be registered.

Reset
REQ-027 On rst_n=0, immediately: state=BOOT, pc=RESET_PC, id_pc=0, id_valid=0, fetch_count=0, misalign_err=0, boot counter=0.
REQ-028 Reset asserted mid-run or mid-redirect SHALL abandon the pending redirect with no residual pulse on misalign_err.

Verification
REQ-029 Reset release, BOOT_CYCLES=2, no stall/jump -> is_jump=1 for edges 1-2; REDIRECT after edge 2; after edge 3 id_valid=1, id_pc=0, pc=4; after edge 4 id_pc=4, fetch_count=1.
REQ-030 RUN at pc=0x10, stall_in=1 for 3 cycles -> is_stoll=1, pc=0x10, id_pc=0x0C, fetch_count frozen; after release pc=0x14 next edge.
REQ-031 RUN, jump_in=1 with stall_in=1, target 0x100 -> is_jump=1, is_stoll=0; next cycle id_valid=0, pc=0x100; following cycle id_valid=1, id_pc=0x100.
REQ-032 Jump to 0x202 -> pc=0x200, misalign_err=1 for one cycle only; then id_pc=0x200.
REQ-033 pc=0xFFFF_FFFC running -> pc=0 next edge; jump in REDIRECT to 0x40 -> stays REDIRECT, pc=0x40.
REQ-034 rst_n asserted during REDIRECT -> outputs at reset values same cycle; full BOOT sequence replays.
